// File: rtl/int_to_float_converter.sv
// int_to_float_converter: three-stage pipelined 32-bit integer to IEEE-754
// single-precision converter (ITOF / UITOF) with valid/ready on both sides.
// Stages: magnitude -> normalize (leading-zero shift) -> round/pack (output).
// Build option: define ITOF_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the mantissa is truncated toward zero.
module int_to_float_converter #(
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_value,
  input  logic                 in_unsigned,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [TAG_WIDTH-1:0] out_tag
);

`ifdef ITOF_ROUND_NEAREST_EN
  localparam int NORM_LO = 0;   // guard and sticky bits are needed downstream
`else
  localparam int NORM_LO = 8;   // bits below the mantissa are never looked at
`endif

  // stage 1 registers
  logic                 s1_valid_q;
  logic                 s1_sign_q, s1_sign_d;
  logic [31:0]          s1_mag_q, s1_mag_d;
  logic                 s1_zero_q, s1_zero_d;
  logic [TAG_WIDTH-1:0] s1_tag_q;

  // stage 2 registers (norm[31] is the implicit leading one and is dropped)
  logic                 s2_valid_q;
  logic                 s2_sign_q;
  logic [30:NORM_LO]    s2_norm_q, s2_norm_d;
  logic [7:0]           s2_exp_q, s2_exp_d;
  logic                 s2_zero_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;

  // stage 3 / output registers
  logic                 s3_valid_q;
  logic [31:0]          s3_result_q, s3_result_d;
  logic [TAG_WIDTH-1:0] s3_tag_q;

  logic en1, en2, en3;
  logic accept;

  // each stage may load when empty or when the stage after it moves on
  always_comb begin
    en3    = ~s3_valid_q | out_ready;
    en2    = ~s2_valid_q | en3;
    en1    = ~s1_valid_q | en2;
    in_ready = reset_n & en1;
    accept = in_valid & in_ready;
  end

  // magnitude: 0x80000000 signed maps onto the unsigned value 0x80000000
  always_comb begin
    s1_sign_d = ~in_unsigned & in_value[31];
    s1_mag_d  = s1_sign_d ? (~in_value + 32'd1) : in_value;
    s1_zero_d = (in_value == 32'd0);
  end

  // stage 1 register: operand sign, magnitude, zero flag and tag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_tag_q   <= '0;
    end else if (en1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_mag_q  <= s1_mag_d;
        s1_zero_q <= s1_zero_d;
        s1_tag_q  <= in_tag;
      end
    end
  end

  // normalize: binary-search leading-zero count, shifting as we go
  always_comb begin
    logic [31:0] m;
    logic [4:0]  lz;
    m  = s1_mag_q;
    lz = 5'd0;
    if (m[31:16] == 16'h0) begin lz[4] = 1'b1; m = m << 16; end
    if (m[31:24] == 8'h0)  begin lz[3] = 1'b1; m = m << 8;  end
    if (m[31:28] == 4'h0)  begin lz[2] = 1'b1; m = m << 4;  end
    if (m[31:30] == 2'h0)  begin lz[1] = 1'b1; m = m << 2;  end
    if (m[31] == 1'b0)     begin lz[0] = 1'b1; m = m << 1;  end
    s2_norm_d = m[30:NORM_LO];
    s2_exp_d  = 8'd158 - {3'b000, lz};
  end

  // stage 2 register: normalized mantissa and biased exponent
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_norm_q  <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_tag_q   <= '0;
    end else if (en2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_norm_q <= s2_norm_d;
        s2_exp_q  <= s2_exp_d;
        s2_zero_q <= s1_zero_q;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  // round/pack: a mantissa carry bumps the exponent; exp tops out at 159
  always_comb begin
    logic [22:0] frac;
    logic [7:0]  exp;
`ifdef ITOF_ROUND_NEAREST_EN
    logic        guard, sticky, round_up;
    logic [23:0] frac_inc;
`endif
    frac = s2_norm_q[30:8];
    exp  = s2_exp_q;
`ifdef ITOF_ROUND_NEAREST_EN
    guard    = s2_norm_q[7];
    sticky   = |s2_norm_q[6:0];
    round_up = guard & (sticky | frac[0]);
    frac_inc = {1'b0, frac} + 24'd1;
    if (round_up) begin
      frac = frac_inc[22:0];
      exp  = exp + {7'd0, frac_inc[23]};
    end
`endif
    s3_result_d = s2_zero_q ? 32'h0000_0000 : {s2_sign_q, exp, frac};
  end

  // output register: holds result and tag steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s3_valid_q  <= 1'b0;
      s3_result_q <= '0;
      s3_tag_q    <= '0;
    end else if (en3) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_result_q <= s3_result_d;
        s3_tag_q    <= s2_tag_q;
      end
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_result = s3_result_q;
  assign out_tag    = s3_tag_q;

endmodule
